match_controller: RTL



---
 rtl/tow_pkg.sv | 27 ++
 rtl/seg7_digit.sv | 11 +
 rtl/match_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match logic.
// Segment patterns are active-low, bit order g..a.
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        HOLD  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } match_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:7] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
    };

    localparam logic [1:0] CHAMP_NONE = 2'b00;
    localparam logic [1:0] CHAMP_P1   = 2'b01;
    localparam logic [1:0] CHAMP_P2   = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// 3-bit value to active-low 7-segment pattern; purely combinational.
module seg7_digit
    import tow_pkg::*;
(
    input  logic [2:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_DIGIT[i_digit];

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: scores rounds, requests playfield resets, declares the champion.
// Score/state update on the win edge; MATCH_AUTO_RESTART_EN re-arms the match from DONE.
module match_controller
    import tow_pkg::*;
#(
    parameter int WIN_TARGET     = 3,
    parameter int HOLD_CYCLES    = 4,
    parameter int RESTART_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_win,
    input  logic       p2_win,
    output logic       round_rst,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic [6:0] hex_p1,
    output logic [6:0] hex_p2,
    output logic       match_over,
    output logic [1:0] champ_id
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, RESTART_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0] WIN_SCORE = 3'(WIN_TARGET);
`ifdef MATCH_AUTO_RESTART_EN
    localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_CYCLES - 1);
`endif

    match_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_score1;
    logic [2:0]       r_score2;
    logic             r_round_rst;
    logic             r_match_over;
    logic [1:0]       r_champ_id;

    logic w_p1_only;
    logic w_p2_only;
    logic w_inputs_idle;

    assign w_p1_only     = p1_win & ~p2_win;
    assign w_p2_only     = p2_win & ~p1_win;
    assign w_inputs_idle = ~p1_win & ~p2_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= PLAY;
            r_cnt        <= '0;
            r_score1     <= '0;
            r_score2     <= '0;
            r_round_rst  <= 1'b0;
            r_match_over <= 1'b0;
            r_champ_id   <= CHAMP_NONE;
        end else begin
            case (r_state)
                PLAY: begin
                    r_cnt <= '0;
                    if (w_p1_only) begin
                        r_score1 <= r_score1 + 3'd1;
                        if (r_score1 + 3'd1 == WIN_SCORE) begin
                            r_state      <= DONE;
                            r_match_over <= 1'b1;
                            r_champ_id   <= CHAMP_P1;
                        end else begin
                            r_state <= HOLD;
                        end
                    end else if (w_p2_only) begin
                        r_score2 <= r_score2 + 3'd1;
                        if (r_score2 + 3'd1 == WIN_SCORE) begin
                            r_state      <= DONE;
                            r_match_over <= 1'b1;
                            r_champ_id   <= CHAMP_P2;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt       <= '0;
                        r_state     <= CLEAR;
                        r_round_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // The detector keeps its win level until it sees round_rst, so wait for both to drop.
                CLEAR: begin
                    if (w_inputs_idle) begin
                        r_state     <= PLAY;
                        r_round_rst <= 1'b0;
                    end
                end
                DONE: begin
`ifdef MATCH_AUTO_RESTART_EN
                    if (r_cnt == RESTART_LAST) begin
                        r_cnt        <= '0;
                        r_score1     <= '0;
                        r_score2     <= '0;
                        r_match_over <= 1'b0;
                        r_champ_id   <= CHAMP_NONE;
                        r_round_rst  <= 1'b1;
                        r_state      <= CLEAR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    r_state <= DONE;
`endif
                end
                default: r_state <= PLAY;
            endcase
        end
    end

    assign round_rst  = r_round_rst;
    assign score1     = r_score1;
    assign score2     = r_score2;
    assign match_over = r_match_over;
    assign champ_id   = r_champ_id;

    seg7_digit u_seg_p1 (
        .i_digit (r_score1),
        .o_seg   (hex_p1)
    );

    seg7_digit u_seg_p2 (
        .i_digit (r_score2),
        .o_seg   (hex_p2)
    );

endmodule
